ps2_scan_receiver: RTL

Fully synchronous PS/2 device-to-host receiver running on clock50.
- Samples PS/2 clock/data through a synchroniser and a parametrised glitch filter.
- Deframes 11-bit frames (start, 8 data LSB-first, odd parity, stop) with frame-error and timeout recovery.
- Buffers scan codes in a FIFO with a valid/ready handshake to the game-input logic.

---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_sync_fifo.sv | 61 ++++++
 rtl/ps2_scan_receiver.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
package ps2_pkg;

    // Deframer states, in the order a frame walks through them.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    // Payload bits per frame, and total bits including start/parity/stop.
    localparam int PS2_DATA_BITS  = 8;
    localparam int PS2_FRAME_BITS = 11;

    // Odd parity holds when data bits plus the parity bit contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                           input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// Show-ahead (first-word-fall-through) synchronous FIFO. A pop is served
// before a push in the same cycle, so a full FIFO can accept a push while
// it is being read.
module ps2_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clock50,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // The head is shown directly; an empty FIFO presents zero rather than stale storage.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Storage write on an accepted push.
    // NOTE: the data array has no reset; only pointers and count need one, since
    // empty masks whatever the array holds.
    always_ff @(posedge clock50) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clock50) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_scan_receiver.sv
// PS/2 device-to-host receiver: synchronises and glitch-filters the PS/2
// clock and data lines, deframes 11-bit frames on filtered falling clock
// edges, and queues scan codes in a show-ahead FIFO with valid/ready.
// Build option: define PS2_PARITY_CHECK_EN to reject frames with bad odd
// parity and expose the parity_err pulse output.
module ps2_scan_receiver
    import ps2_pkg::*;
#(
    parameter int SAMPLE_DIV     = 2,
    parameter int FILTER_LEN     = 8,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                          clock50,
    input  logic                          reset,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic                          code_valid,
    input  logic                          code_ready,
    output logic [PS2_DATA_BITS-1:0]      code_data,
    output logic                          frame_err,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef PS2_PARITY_CHECK_EN
    ,
    output logic                          parity_err
`endif
);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_DATA   = DATA;
    localparam logic [1:0] S_PARITY = PARITY;
    localparam logic [1:0] S_STOP   = STOP;

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int BIT_W = $clog2(PS2_DATA_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(PS2_DATA_BITS - 1);

    logic [1:0]                clk_sync;
    logic [1:0]                data_sync;
    logic [DIV_W-1:0]          div_cnt;
    logic                      sample_stb;
    logic [FILTER_LEN-1:0]     clk_hist;
    logic [FILTER_LEN-1:0]     data_hist;
    logic [FILTER_LEN-1:0]     clk_hist_nxt;
    logic [FILTER_LEN-1:0]     data_hist_nxt;
    logic                      clk_filt;
    logic                      data_filt;
    logic                      clk_filt_d;
    logic                      fall_stb;

    logic [1:0]                state;
    logic [BIT_W-1:0]          bit_cnt;
    logic [PS2_DATA_BITS-1:0]  shreg;
    logic [TMO_W-1:0]          tmo_cnt;
    logic                      push_req;
`ifdef PS2_PARITY_CHECK_EN
    logic                      par_bit;
`endif

    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      fifo_pop;

    // Two-flop synchronisers; the idle PS/2 bus is high, so they reset to ones.
    // NOTE: registers are updated with non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour.
    always_ff @(posedge clock50) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // Sample strobe every SAMPLE_DIV cycles.
    assign sample_stb = (div_cnt == DIV_LAST);

    // Free-running sample divider.
    always_ff @(posedge clock50) begin
        if (reset || sample_stb) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Sample history including the sample being taken this strobe.
    assign clk_hist_nxt  = {clk_hist[FILTER_LEN-2:0], clk_sync[1]};
    assign data_hist_nxt = {data_hist[FILTER_LEN-2:0], data_sync[1]};

    // Glitch filter: a level flips only after FILTER_LEN identical samples.
    always_ff @(posedge clock50) begin
        if (reset) begin
            clk_hist  <= '1;
            data_hist <= '1;
            clk_filt  <= 1'b1;
            data_filt <= 1'b1;
        end else if (sample_stb) begin
            clk_hist  <= clk_hist_nxt;
            data_hist <= data_hist_nxt;
            if (&clk_hist_nxt)        clk_filt  <= 1'b1;
            else if (~|clk_hist_nxt)  clk_filt  <= 1'b0;
            if (&data_hist_nxt)       data_filt <= 1'b1;
            else if (~|data_hist_nxt) data_filt <= 1'b0;
        end
    end

    // Delayed filtered clock for falling-edge detection.
    always_ff @(posedge clock50) begin
        if (reset) begin
            clk_filt_d <= 1'b1;
        end else begin
            clk_filt_d <= clk_filt;
        end
    end

    assign fall_stb = clk_filt_d && !clk_filt;

    // Deframer FSM with mid-frame timeout; frame_err and push_req are one-cycle pulses.
    always_ff @(posedge clock50) begin
        if (reset) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            tmo_cnt   <= '0;
            frame_err <= 1'b0;
            push_req  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            push_req  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            parity_err <= 1'b0;
`endif
            // Timeout counter runs only mid-frame and restarts on every bit edge.
            if (state == S_IDLE || fall_stb) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (state != S_IDLE && !fall_stb && tmo_cnt == TMO_LAST) begin
                // Device stalled mid-frame: drop the partial frame.
                state     <= S_IDLE;
                frame_err <= 1'b1;
            end else if (fall_stb) begin
                case (state)
                    S_IDLE: begin
                        // A high level on a falling edge is not a start bit; ignore it.
                        if (!data_filt) begin
                            state   <= S_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    S_DATA: begin
                        shreg   <= {data_filt, shreg[PS2_DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BIT_LAST) begin
                            state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                        par_bit <= data_filt;
`endif
                        // Without the parity check the bit is sampled and discarded.
                        state <= S_STOP;
                    end
                    S_STOP: begin
                        state <= S_IDLE;
                        if (data_filt) begin
`ifdef PS2_PARITY_CHECK_EN
                            if (odd_parity_ok(shreg, par_bit)) begin
                                push_req <= 1'b1;
                            end else begin
                                frame_err  <= 1'b1;
                                parity_err <= 1'b1;
                            end
`else
                            push_req <= 1'b1;
`endif
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign fifo_pop = code_valid && code_ready;

    ps2_sync_fifo #(
        .WIDTH (PS2_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock50   (clock50),
        .reset     (reset),
        .push      (push_req),
        .push_data (shreg),
        .pop       (fifo_pop),
        .pop_data  (code_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign code_valid = !fifo_empty;

    // Sticky overflow: a completed code found the FIFO full with no pop to make room.
    always_ff @(posedge clock50) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (push_req && fifo_full && !fifo_pop) begin
            overflow <= 1'b1;
        end
    end

endmodule
